apu_square_bank: RTL and testbench

- Parametrised successor to the fixed two-instance square-channel arrangement. Holds NUM_CH identical pulse channels behind one register window.
- Each channel has a timer, a duty sequencer, an envelope and a length counter.
- Per-channel 4-bit outputs and a summed mix output feed the DAC stage.
- Frame ticks come from the soft timer as single-cycle pulses. Channel timers advance on the APU clock enable.

---
 rtl/apu_square_bank_if.sv | 22 ++
 rtl/apu_square_bank.sv | 117 +++++++++++
 tb/tb_apu_square_bank.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/apu_square_bank_if.sv
// apu_square_bank_if: register-write and frame-tick bus into the pulse bank, DAC-side outputs back.
//   aclk    APU clock enable (timers)
//   qframe  quarter-frame tick (envelopes)
//   hframe  half-frame tick (length counters)
//   we      register write strobe; waddr = {channel[2:0], reg[1:0]}, wdata = data
//   en_we   channel-enable write; wdata[NUM_CH-1:0] is the mask
//   lc_nz   per-channel length counter != 0
//   ch_out  per-channel 4-bit volume, channel i at [4i+3:4i]
//   mix     sum of all ch_out nibbles
interface apu_square_bank_if #(
    parameter int NUM_CH = 2,
    parameter int MIX_W  = 7
);
    logic                aclk, qframe, hframe, we, en_we;
    logic [4:0]          waddr;
    logic [7:0]          wdata;
    logic [NUM_CH-1:0]   lc_nz;
    logic [4*NUM_CH-1:0] ch_out;
    logic [MIX_W-1:0]    mix;
    modport master (output aclk, qframe, hframe, we, waddr, wdata, en_we, input lc_nz, ch_out, mix);
    modport slave  (input aclk, qframe, hframe, we, waddr, wdata, en_we, output lc_nz, ch_out, mix);
endinterface

// File: rtl/apu_square_bank.sv
// apu_square_bank: NUM_CH pulse channels (timer, duty sequencer, envelope, length counter) behind one register window.
//   clk_i  system clock
//   rst_i  synchronous active-high reset
//   bus    apu_square_bank_if slave: ticks and register writes in, lc_nz/ch_out/mix out
module apu_square_bank #(
    parameter int NUM_CH  = 2,
    parameter int TIMER_W = 11,
    parameter int MIX_W   = 7
) (
    input logic              clk_i,
    input logic              rst_i,
    apu_square_bank_if.slave bus
);
    localparam logic [7:0] LEN_TABLE [32] = '{
        8'd10, 8'd254, 8'd20, 8'd2, 8'd40, 8'd4, 8'd80, 8'd6,
        8'd160, 8'd8, 8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
        8'd12, 8'd16, 8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
        8'd192, 8'd24, 8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
    };
    // bit n of each entry is the output level at duty step n
    localparam logic [7:0] DUTY_TAB [4] = '{8'b0000_0010, 8'b0000_0110, 8'b0001_1110, 8'b1111_1001};

    typedef struct packed {
        logic [1:0]         duty;
        logic               loop;
        logic               cnst;
        logic [3:0]         vol;
        logic [TIMER_W-1:0] period;
        logic [TIMER_W-1:0] timer;
        logic [2:0]         step;
        logic               start;
        logic [3:0]         div;
        logic [3:0]         decay;
        logic [7:0]         len;
    } ch_t;

    ch_t                 ch_q [NUM_CH];
    ch_t                 ch_d [NUM_CH];
    logic [NUM_CH-1:0]   en_q, en_d, lc_nz_q, lc_nz_d;
    logic [4*NUM_CH-1:0] ch_out_q, ch_out_d;
    logic [MIX_W-1:0]    mix_q, mix_d;
    logic [7:0]          wsel;

    // one-hot channel select; indices >= NUM_CH never match a channel
    assign wsel = bus.we ? 8'(1) << bus.waddr[4:2] : 8'd0;

    always_comb begin
        en_d     = bus.en_we ? bus.wdata[NUM_CH-1:0] : en_q;
        lc_nz_d  = '0;
        ch_out_d = '0;
        mix_d    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_d[c] = ch_q[c];
            if (bus.aclk) begin
                if (ch_q[c].timer == '0) begin
                    ch_d[c].timer = ch_q[c].period;
                    ch_d[c].step  = ch_q[c].step + 3'd1;
                end else begin
                    ch_d[c].timer = ch_q[c].timer - TIMER_W'(1);
                end
            end
            if (bus.qframe) begin
                if (ch_q[c].start) begin
                    ch_d[c].start = 1'b0;
                    ch_d[c].decay = 4'd15;
                    ch_d[c].div   = ch_q[c].vol;
                end else if (ch_q[c].div == 4'd0) begin
                    ch_d[c].div   = ch_q[c].vol;
                    ch_d[c].decay = ch_q[c].decay != 4'd0 ? ch_q[c].decay - 4'd1 : (ch_q[c].loop ? 4'd15 : 4'd0);
                end else begin
                    ch_d[c].div = ch_q[c].div - 4'd1;
                end
            end
            if (bus.hframe && !ch_q[c].loop && ch_q[c].len != 8'd0)
                ch_d[c].len = ch_q[c].len - 8'd1;
            if (wsel[c]) begin
                case (bus.waddr[1:0])
                    2'd0: {ch_d[c].duty, ch_d[c].loop, ch_d[c].cnst, ch_d[c].vol} = bus.wdata;
                    2'd2: ch_d[c].period[7:0] = bus.wdata;
                    2'd3: begin
                        ch_d[c].period = (TIMER_W'(bus.wdata[2:0]) << 8) | TIMER_W'(ch_q[c].period[7:0]);
                        ch_d[c].step   = 3'd0;
                        ch_d[c].start  = 1'b1;
                        if (en_d[c]) ch_d[c].len = LEN_TABLE[bus.wdata[7:3]];
                    end
                    default: ;
                endcase
            end
            // a cleared enable bit beats any load in the same cycle
            if (!en_d[c]) ch_d[c].len = 8'd0;
            lc_nz_d[c] = ch_q[c].len != 8'd0;
            ch_out_d[4*c +: 4] = (ch_q[c].period < TIMER_W'(8) || ch_q[c].len == 8'd0 || !DUTY_TAB[ch_q[c].duty][ch_q[c].step])
                ? 4'd0 : (ch_q[c].cnst ? ch_q[c].vol : ch_q[c].decay);
            mix_d = mix_d + MIX_W'(ch_out_q[4*c +: 4]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) ch_q[c] <= '0;
            en_q     <= '0;
            lc_nz_q  <= '0;
            ch_out_q <= '0;
            mix_q    <= '0;
        end else begin
            ch_q     <= ch_d;
            en_q     <= en_d;
            lc_nz_q  <= lc_nz_d;
            ch_out_q <= ch_out_d;
            mix_q    <= mix_d;
        end
    end

    assign bus.lc_nz  = lc_nz_q;
    assign bus.ch_out = ch_out_q;
    assign bus.mix    = mix_q;
endmodule

// File: tb/tb_apu_square_bank.sv
// tb_apu_square_bank: directed self-checking bench for a 4-channel apu_square_bank.
module tb_apu_square_bank;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    apu_square_bank_if #(.NUM_CH(4), .MIX_W(7)) bus ();
    apu_square_bank #(.NUM_CH(4), .TIMER_W(11), .MIX_W(7)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.aclk = 0; bus.qframe = 0; bus.hframe = 0;
        bus.we = 0; bus.en_we = 0; bus.waddr = '0; bus.wdata = '0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        bus.we = 1; bus.waddr = a; bus.wdata = d;
        step();
        bus.we = 0;
    endtask

    task automatic en(input logic [7:0] m);
        bus.en_we = 1; bus.wdata = m;
        step();
        bus.en_we = 0;
    endtask

    task automatic aclk_pulse();
        bus.aclk = 1; step(); bus.aclk = 0; step();
    endtask

    task automatic q_pulse();
        bus.qframe = 1; step(); bus.qframe = 0; step();
    endtask

    task automatic h_pulse();
        bus.hframe = 1; step(); bus.hframe = 0; step();
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    initial begin
        idle();
        // reset held two cycles under heavy traffic
        rst = 1; bus.we = 1; bus.waddr = 5'd3; bus.wdata = 8'hFF; bus.en_we = 1;
        bus.aclk = 1; bus.qframe = 1; bus.hframe = 1;
        step();
        bus.waddr = 5'd0;
        step();
        idle(); rst = 0;
        check("rst_ch_out", bus.ch_out, 0);
        check("rst_lc_nz", bus.lc_nz, 0);
        check("rst_mix", bus.mix, 0);
        step();
        check("rst_ch_out2", bus.ch_out, 0);
        wr(5'd3, 8'h08); step(); step();
        check("rst_no_enable", bus.lc_nz, 0);

        // duty 2, constant volume 15, period 8: 36 ACLKs high, 36 low
        en(8'h01); wr(5'd0, 8'hBF); wr(5'd2, 8'h08); wr(5'd3, 8'h08); step();
        check("duty_step0", bus.ch_out[3:0], 0);
        check("duty_lc_nz", bus.lc_nz, 4'b0001);
        for (int n = 1; n <= 80; n++) begin
            aclk_pulse();
            check("duty", bus.ch_out[3:0], (((n - 1) / 36) % 2 == 0) ? 15 : 0);
        end

        // period below 8 mutes while length stays live
        wr(5'd2, 8'h07); step(); step();
        for (int n = 0; n < 10; n++) begin
            aclk_pulse();
            check("mute", bus.ch_out[3:0], 0);
        end
        check("mute_lc_nz", bus.lc_nz, 4'b0001);

        // envelope decay, EPER=2, duty 3 held at step 0 (always high)
        do_reset();
        en(8'h01); wr(5'd0, 8'hC2); wr(5'd2, 8'h08); wr(5'd3, 8'h08); step();
        check("env_pre", bus.ch_out[3:0], 0);
        for (int n = 1; n <= 52; n++) begin
            int e;
            q_pulse();
            e = 15 - (n - 1) / 3;
            check("env_decay", bus.ch_out[3:0], e < 0 ? 0 : e);
        end
        wr(5'd0, 8'hE2);
        q_pulse(); check("env_loop53", bus.ch_out[3:0], 0);
        q_pulse(); check("env_loop54", bus.ch_out[3:0], 0);
        q_pulse(); check("env_loop55", bus.ch_out[3:0], 15);
        q_pulse(); check("env_loop56", bus.ch_out[3:0], 15);

        // length counter, LIDX 0 = 10
        wr(5'd0, 8'h1F); wr(5'd3, 8'h00); step();
        check("len_load", bus.lc_nz[0], 1);
        for (int k = 1; k <= 10; k++) begin
            h_pulse();
            check("len_count", bus.lc_nz[0], k < 10);
        end
        bus.we = 1; bus.waddr = 5'd3; bus.wdata = 8'h00; bus.hframe = 1;
        step(); idle(); step();
        check("len_coinc_load", bus.lc_nz[0], 1);
        for (int k = 1; k <= 10; k++) begin
            h_pulse();
            check("len_coinc_count", bus.lc_nz[0], k < 10);
        end
        wr(5'd3, 8'h00); step();
        check("len_reload", bus.lc_nz[0], 1);
        en(8'h00); step();
        check("len_disable", bus.lc_nz[0], 0);
        wr(5'd3, 8'h00); step(); step();
        check("len_held_zero", bus.lc_nz[0], 0);
        en(8'h01); wr(5'd3, 8'h00); step();
        check("len_reenable", bus.lc_nz[0], 1);
        bus.en_we = 1; bus.we = 1; bus.waddr = 5'd3; bus.wdata = 8'h00;
        step(); idle(); step();
        check("len_clear_vs_load", bus.lc_nz[0], 0);
        en(8'h01); wr(5'd0, 8'h3F); wr(5'd3, 8'h00);
        for (int k = 0; k < 12; k++) h_pulse();
        check("len_halt", bus.lc_nz[0], 1);

        // four channels, duty 3, constant 15, step 0
        do_reset();
        en(8'h0F);
        for (int c = 0; c < 4; c++) begin
            wr(5'(c * 4), 8'hDF);
            wr(5'(c * 4 + 2), 8'h08);
            wr(5'(c * 4 + 3), 8'h08);
        end
        step();
        check("multi_ch_out", bus.ch_out, 16'hFFFF);
        check("multi_mix_lag", bus.mix, 45);
        step();
        check("multi_mix", bus.mix, 60);
        wr(5'd20, 8'h00); wr(5'd23, 8'h00); step(); step();
        check("bad_ch_ch_out", bus.ch_out, 16'hFFFF);
        check("bad_ch_mix", bus.mix, 60);
        check("bad_ch_lc_nz", bus.lc_nz, 4'hF);

        // reset mid-operation discards a coincident write
        rst = 1; bus.we = 1; bus.waddr = 5'd3; bus.wdata = 8'h08;
        step(); rst = 0; idle();
        check("rst_op_ch_out", bus.ch_out, 0);
        check("rst_op_lc_nz", bus.lc_nz, 0);
        check("rst_op_mix", bus.mix, 0);
        step(); step();
        check("rst_op_discard", bus.lc_nz, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
